// File: rtl/commit_checker.sv
// In-order commit checker: matches core pc/aluout against a loadable (pc, expected) table.
// Optional COMMIT_CHECKER_STOP_ON_ERR_EN ends the run on the first mismatching entry.
module commit_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_pc,
  input  logic [WIDTH-1:0] cfg_exp,
  input  logic [AW:0]      cfg_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] aluout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [AW:0]      chk_cnt,
  output logic [15:0]      err_cnt,
  output logic [WIDTH-1:0] first_err_pc
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tbl_pc  [DEPTH];
  logic [WIDTH-1:0] tbl_exp [DEPTH];
  logic [AW:0]      ptr, n_lat, n_clamp;
  logic [WW-1:0]    wdog;
  logic [WIDTH-1:0] rd_pc, rd_exp;
  logic             hit, mism, launch, to_set, wdog_exp;

  // Table is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (cfg_we && state != S_RUN) begin
      tbl_pc[cfg_addr]  <= cfg_pc;
      tbl_exp[cfg_addr] <= cfg_exp;
    end
  end

  assign rd_pc    = tbl_pc[ptr[AW-1:0]];
  assign rd_exp   = tbl_exp[ptr[AW-1:0]];
  assign n_clamp  = (cfg_n > DEPTH_L) ? DEPTH_L : cfg_n;
  assign wdog_exp = (wdog == WW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    mism      = 1'b0;
    launch    = 1'b0;
    to_set    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (ptr == n_lat) begin
          state_nxt = S_DONE;
        end else begin
          hit  = (pc == rd_pc);
          mism = hit && (aluout != rd_exp);
          // A match on the final entry completes the run even if the watchdog expires.
          if (hit && (ptr + (AW+1)'(1) == n_lat)) begin
            state_nxt = S_DONE;
`ifdef COMMIT_CHECKER_STOP_ON_ERR_EN
          end else if (mism) begin
            state_nxt = S_DONE;
`endif
          end else if (wdog_exp) begin
            state_nxt = S_DONE;
            to_set    = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      n_lat        <= '0;
      wdog         <= '0;
      chk_cnt      <= '0;
      err_cnt      <= '0;
      first_err_pc <= '0;
      timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        n_lat        <= n_clamp;
        ptr          <= '0;
        wdog         <= '0;
        chk_cnt      <= '0;
        err_cnt      <= '0;
        first_err_pc <= '0;
        timeout      <= 1'b0;
      end else if (state == S_RUN) begin
        if (hit) begin
          chk_cnt <= chk_cnt + (AW+1)'(1);
          ptr     <= ptr + (AW+1)'(1);
          wdog    <= '0;
          if (mism) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0)    first_err_pc <= pc;
          end
        end else begin
          wdog <= wdog + WW'(1);
        end
        if (to_set) timeout <= 1'b1;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 16'd0) && !timeout;

endmodule

// File: tb/tb_commit_checker.sv
// Randomized scoreboard bench for commit_checker against a trace-walking reference model.
module tb_commit_checker;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] FILL = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic reset, cfg_we, start;
  logic [AW-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_pc, cfg_exp, pc, aluout;
  logic [AW:0] cfg_n;
  logic busy, done, pass, timeout;
  logic [AW:0] chk_cnt;
  logic [15:0] err_cnt;
  logic [WIDTH-1:0] first_err_pc;

  always #5 clk = ~clk;

  commit_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pc(cfg_pc),
    .cfg_exp(cfg_exp), .cfg_n(cfg_n), .start(start), .pc(pc), .aluout(aluout),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .chk_cnt(chk_cnt),
    .err_cnt(err_cnt), .first_err_pc(first_err_pc)
  );

  typedef struct {
    int          chk;
    int          err;
    logic [31:0] first;
    bit          to;
    int          lat;
  } res_t;

  int compared   = 0;
  int mismatched = 0;
  res_t exp_q[$];
  logic [31:0] tr_pc[$], tr_alu[$];
  logic [31:0] m_pc[DEPTH], m_exp[DEPTH];
  logic [31:0] prog_pc[9]  = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h20};
  logic [31:0] prog_alu[9] = '{32'd0, 32'd2, 32'd4, 32'd1, 32'd3, 32'd2, 32'd0, 32'd0, 32'd0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Walk the trace: entries must appear in table order; anything else only ages the watchdog.
  function automatic res_t model(input int n);
    res_t r;
    int idx = 0, gap = 0, t = 0;
    bit stop = 0, bad;
    logic [31:0] p, a;
`ifdef COMMIT_CHECKER_STOP_ON_ERR_EN
    stop = 1;
`endif
    r.chk = 0; r.err = 0; r.first = 0; r.to = 0; r.lat = 0;
    if (n == 0) return r;
    forever begin
      p = (t < tr_pc.size()) ? tr_pc[t] : FILL;
      a = (t < tr_alu.size()) ? tr_alu[t] : 32'd0;
      if (p == m_pc[idx]) begin
        r.chk++;
        bad = (a != m_exp[idx]);
        if (bad) begin
          if (r.err == 0) r.first = p;
          r.err++;
        end
        idx++;
        if (idx == n) break;
        if (stop && bad) break;
        if (gap == TIMEOUT - 1) begin r.to = 1; break; end
        gap = 0;
      end else begin
        if (gap == TIMEOUT - 1) begin r.to = 1; break; end
        gap++;
      end
      t++;
    end
    r.lat = t;
    return r;
  endfunction

  task automatic write_entry(input int addr, input logic [31:0] p, input logic [31:0] e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_pc = p; cfg_exp = e;
    m_pc[addr] = p; m_exp[addr] = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 9; i++) write_entry(i, prog_pc[i], prog_alu[i]);
  endtask

  // Program trace with a few unrelated PCs (branch targets) interleaved.
  task automatic prog_trace(input int upto);
    tr_pc.delete(); tr_alu.delete();
    for (int i = 0; i < upto; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        tr_pc.push_back(32'h1000 + 4 * $urandom_range(0, 15));
        tr_alu.push_back($urandom);
      end
      tr_pc.push_back(prog_pc[i]);
      tr_alu.push_back(prog_alu[i]);
    end
  endtask

  // abort_at>0: reset once chk_cnt reaches that value (no result expected).
  task automatic do_run(input int n_cfg, input bit wr_start, input int abort_at, input bit inrun_wr);
    int n, k, bound, wa;
    bit fin;
    logic [31:0] wp, we_;
    @(negedge clk);
    cfg_n = (AW+1)'(n_cfg);
    start = 1'b1;
    if (wr_start) begin
      wa = $urandom_range(0, DEPTH - 1);
      wp = 4 * $urandom_range(0, 63);
      we_ = $urandom_range(0, 7);
      cfg_we = 1'b1; cfg_addr = AW'(wa); cfg_pc = wp; cfg_exp = we_;
      m_pc[wa] = wp; m_exp[wa] = we_;
    end
    n = (n_cfg > DEPTH) ? DEPTH : n_cfg;
    if (abort_at == 0) exp_q.push_back(model(n));
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    k = 0;
    fin = 0;
    bound = tr_pc.size() + TIMEOUT + 8;
    while (!done && k < bound) begin
      if (abort_at > 0 && int'(chk_cnt) == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_chk_cnt", chk_cnt, 0);
        chk("abort_err_cnt", err_cnt, 0);
        chk("abort_first_err_pc", first_err_pc, 0);
        chk("abort_timeout", timeout, 0);
        fin = 1;
        break;
      end
      pc     = (k < tr_pc.size()) ? tr_pc[k] : FILL;
      aluout = (k < tr_alu.size()) ? tr_alu[k] : 32'd0;
      cfg_we = 1'b0;
      if (inrun_wr && k == 2) begin
        cfg_we = 1'b1; cfg_addr = AW'(3); cfg_pc = 32'hABC0; cfg_exp = 32'h77;
      end
      @(negedge clk);
      k++;
    end
    cfg_we = 1'b0;
    pc = FILL; aluout = 32'd0;
    if (!done && !fin) begin
      compared++; mismatched++;
      $display("FAIL run_bound: no done within %0d cycles", bound);
      exp_q.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  // Monitor: pops an expectation on every rising done.
  bit   done_q = 0, busy_q = 0;
  int   run_cyc = 0;
  res_t got_r;
  initial begin
    forever begin
      @(negedge clk);
      if (busy && !busy_q) run_cyc = 0;
      else if (busy) run_cyc++;
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_done: got done with no pending run");
        end else begin
          got_r = exp_q.pop_front();
          chk("chk_cnt", chk_cnt, got_r.chk);
          chk("err_cnt", err_cnt, got_r.err);
          chk("first_err_pc", first_err_pc, got_r.first);
          chk("timeout", timeout, got_r.to);
          chk("pass", pass, (got_r.err == 0) && !got_r.to);
          chk("latency", run_cyc, got_r.lat);
        end
      end
      done_q = done;
      busy_q = busy;
    end
  end

  initial begin
    int n;
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_pc = '0; cfg_exp = '0;
    cfg_n = '0; pc = FILL; aluout = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_chk_cnt", chk_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err_pc", first_err_pc, 0);

    // Program runs pass, then a wrong expectation at 0x14.
    load_prog();
    prog_trace(9);
    do_run(9, 0, 0, 0);
    write_entry(5, 32'h14, 32'd5);
    do_run(9, 0, 0, 0);
    write_entry(5, 32'h14, 32'd2);

    // An entry whose PC is never reached ends in a timeout.
    write_entry(9, 32'h40, 32'd0);
    do_run(10, 0, 0, 0);

    // Empty table.
    tr_pc.delete(); tr_alu.delete();
    do_run(0, 0, 0, 0);

    // Reset after four checks, then restart on the retained table.
    prog_trace(9);
    do_run(9, 0, 4, 0);
    do_run(9, 0, 0, 0);

    // Writes during a run are ignored; rerun on the same table.
    do_run(9, 0, 0, 1);
    do_run(9, 0, 0, 0);

    // cfg_n beyond DEPTH clamps to a full table.
    for (int i = 0; i < DEPTH; i++) write_entry(i, 32'h200 + 4 * i, $urandom_range(0, 7));
    tr_pc.delete(); tr_alu.delete();
    for (int i = 0; i < DEPTH; i++) begin
      tr_pc.push_back(m_pc[i]);
      tr_alu.push_back(m_exp[i]);
    end
    do_run(20, 0, 0, 0);

    // Random tables and traces.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 18);
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 1) == 0) write_entry(i, 4 * $urandom_range(0, 63), $urandom_range(0, 7));
      tr_pc.delete(); tr_alu.delete();
      for (int i = 0; i < ((n > DEPTH) ? DEPTH : n); i++) begin
        int gap;
        gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(50, 70)) : int'($urandom_range(0, 3));
        for (int j = 0; j < gap; j++) begin
          tr_pc.push_back(4 * $urandom_range(0, 63));
          tr_alu.push_back($urandom_range(0, 7));
        end
        if ($urandom_range(0, 11) == 0) break;
        tr_pc.push_back(m_pc[i]);
        tr_alu.push_back(($urandom_range(0, 5) == 0) ? m_exp[i] + 32'd1 : m_exp[i]);
      end
      do_run(n, ($urandom_range(0, 3) == 0), 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
